motor_drive_seq: RTL and testbench
==================================

MOTOR_DRIVE_SEQ -- requirements
Module: motor_drive_seq

Interface
REQ-001 Parameter PERIOD, default 50000, PWM period in clk cycles.
REQ-002 Parameter DUTY_SCALE, default 500, clk cycles per duty percent; PERIOD SHALL equal 100*DUTY_SCALE.
REQ-003 Parameter NODE_W, default 8, width of node_id.
REQ-004 Parameters D_BASE, D_SOFT, D_SOFTL and D_HARD, defaults 73, 83, 68 and 88, line-follow duty percents.
REQ-005 Parameters D_TURN_L and D_TURN_R, defaults 87 and 85, turn duty percents.
REQ-006 Parameters DLY_L, DLY_R and DLY_U, defaults 20000000, 12000000 and 12000000, pre-turn delay in cycles.
REQ-007 Parameters TRN_L, TRN_R and TRN_U, defaults 25000000, 25000000 and 50000000, turn duration in cycles.
REQ-008 Port clk, input, 1, sole clock; all logic is rising-edge.
REQ-009 Port rst_n, input, 1, reset; synchronous, active-low.
REQ-010 Port line_sensor, input, 3, line sensors {left, centre, right}; 1 means line seen.
REQ-011 Port stop, input, 1, brake request.
REQ-012 Port node_id, input, NODE_W, current node number.
REQ-013 Port dir, input, 2, action at next node: 00 straight, 01 right, 10 left, 11 U-turn.
REQ-014 Port motor_a, output, 2, right H-bridge inputs: 10 forward, 01 reverse, 00 coast, 11 brake.
REQ-015 Port motor_b, output, 2, left H-bridge inputs, same encoding as motor_a.
REQ-016 Port turn_busy, output, 1, high while the FSM is in DELAY or TURN.
REQ-017 Port turn_done, output, 1, one-cycle pulse when a turn completes.

Function
REQ-018 PWM counter SHALL count 1..PERIOD, then wrap to 1, free-running and never frozen by stop.
REQ-019 Active phase SHALL be counter <= duty*DUTY_SCALE; outside it the channel SHALL drive 00 (coast).
REQ-020 Duty registers duty_a/duty_b SHALL update one cycle after line_sensor changes, in FOLLOW state only, per the table below.
  - 100: duty_a=D_SOFT, duty_b=D_SOFTL
  - 110: duty_a=D_HARD, duty_b=D_BASE
  - 010 and 111: both D_BASE
  - 011: duty_a=D_BASE, duty_b=D_HARD
  - 001: duty_a=D_SOFTL, duty_b=D_SOFT
  - 000 and 101: hold the previous values
REQ-021 FSM states SHALL be FOLLOW, DELAY and TURN.
REQ-022 FOLLOW SHALL go to DELAY when dir!=00 and node_id!=last_node; it SHALL latch dir into act and clear the phase counter.
REQ-023 DELAY SHALL last DLY_x cycles, selected by act; throughout DELAY both motors SHALL keep line-following.
REQ-024 TURN SHALL last TRN_x cycles; in the active phase the motors SHALL drive as follows.
  - Left: motor_a=10, motor_b=01 at D_TURN_L.
  - Right/U: motor_a=01, motor_b=10 at D_TURN_R.
REQ-025 On TURN expiry the FSM SHALL return to FOLLOW, set last_node<=node_id and pulse turn_done for exactly 1 cycle.
REQ-026 dir and node_id changes during DELAY or TURN SHALL be ignored.
REQ-027 dir=00 in FOLLOW SHALL never start a turn; a repeated node_id SHALL not retrigger a turn.
REQ-028 While stop=1, motor_a and motor_b SHALL be 11 (highest priority) and the FSM phase counter SHALL hold.
REQ-029 Operation SHALL resume exactly where it left off on stop falling.
REQ-030 Outputs SHALL be registered: one-cycle latency from counter/state to pins.
REQ-031 The phase counter SHALL be wide enough for max(DLY_x, TRN_x) with no wrap.

Reset
REQ-032 With rst_n=0 at a clk edge, the block SHALL set:
  - motor_a=00, motor_b=00
  - turn_busy=0, turn_done=0
  - state FOLLOW, PWM counter 1, phase counter 0
  - last_node=0, duty_a=duty_b=D_BASE
REQ-033 Reset mid-turn SHALL abort the turn with no turn_done pulse.

Verification (PERIOD=100, DUTY_SCALE=1, DLY_x=10, TRN_L=20, TRN_R=20, TRN_U=40)
REQ-034 Follow test: line_sensor=010 -> both motors 10 for 73 of every 100 cycles, 00 for 27.
REQ-035 Correction test: line_sensor=100 -> motor_a high 83/100 and motor_b high 68/100; then 000 -> duties unchanged.
REQ-036 Left turn test: dir=10, node_id 0->5 -> turn_busy rises next cycle.
  - Follow continues for 10 cycles.
  - Then 20 cycles of a=10 / b=01 pulses at 87%.
  - turn_done pulses once; node 5 held with no retrigger.
REQ-037 Stop test: stop=1 mid-TURN for 30 cycles -> both 11; on release the remaining TURN cycles complete, total TURN still 20 unstopped cycles.
REQ-038 Reset test: rst_n=0 during DELAY of a U-turn -> next cycle outputs 00, turn_busy=0, no turn_done; same node_id afterwards starts a new turn, since last_node=0.
REQ-039 Ignore test: dir changed 01->10 during DELAY -> turn executes as right (a=01, b=10).

Source files
------------

// File: rtl/motor_drive_seq.sv
// Two-channel H-bridge PWM driver with line following and timed node turns.
// A FOLLOW/DELAY/TURN sequencer overrides line-follow duties while a turn executes.
module motor_drive_seq #(
  parameter int PERIOD     = 50000,
  parameter int DUTY_SCALE = 500,
  parameter int NODE_W     = 8,
  parameter int D_BASE     = 73,
  parameter int D_SOFT     = 83,
  parameter int D_SOFTL    = 68,
  parameter int D_HARD     = 88,
  parameter int D_TURN_L   = 87,
  parameter int D_TURN_R   = 85,
  parameter int DLY_L      = 20000000,
  parameter int DLY_R      = 12000000,
  parameter int DLY_U      = 12000000,
  parameter int TRN_L      = 25000000,
  parameter int TRN_R      = 25000000,
  parameter int TRN_U      = 50000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        line_sensor,
  input  logic              stop,
  input  logic [NODE_W-1:0] node_id,
  input  logic [1:0]        dir,
  output logic [1:0]        motor_a,
  output logic [1:0]        motor_b,
  output logic              turn_busy,
  output logic              turn_done
);

  localparam int PWM_W   = $clog2(PERIOD + 1);
  localparam int DLY_MAX = (DLY_L > DLY_R) ? ((DLY_L > DLY_U) ? DLY_L : DLY_U)
                                           : ((DLY_R > DLY_U) ? DLY_R : DLY_U);
  localparam int TRN_MAX = (TRN_L > TRN_R) ? ((TRN_L > TRN_U) ? TRN_L : TRN_U)
                                           : ((TRN_R > TRN_U) ? TRN_R : TRN_U);
  localparam int PH_MAX  = (DLY_MAX > TRN_MAX) ? DLY_MAX : TRN_MAX;
  localparam int PH_W    = $clog2(PH_MAX + 1);

  localparam logic [6:0] P_BASE  = 7'(D_BASE);
  localparam logic [6:0] P_SOFT  = 7'(D_SOFT);
  localparam logic [6:0] P_SOFTL = 7'(D_SOFTL);
  localparam logic [6:0] P_HARD  = 7'(D_HARD);

  localparam logic [1:0] FWD   = 2'b10;
  localparam logic [1:0] REV   = 2'b01;
  localparam logic [1:0] COAST = 2'b00;
  localparam logic [1:0] BRAKE = 2'b11;

  typedef enum logic [1:0] {FOLLOW, DELAY, TURN} state_t;

  state_t            state;
  logic [1:0]        act;
  logic [PH_W-1:0]   phase_cnt;
  logic [NODE_W-1:0] last_node;
  logic [PWM_W-1:0]  pwm_cnt;
  logic [6:0]        duty_a;
  logic [6:0]        duty_b;

  logic [31:0]     pwm_ext;
  logic [31:0]     thr_a;
  logic [31:0]     thr_b;
  logic [31:0]     thr_tl;
  logic [31:0]     thr_tr;
  logic [PH_W-1:0] dly_last;
  logic [PH_W-1:0] trn_last;
  logic [1:0]      next_a;
  logic [1:0]      next_b;

  assign pwm_ext = 32'(pwm_cnt);
  assign thr_a   = 32'(duty_a) * DUTY_SCALE;
  assign thr_b   = 32'(duty_b) * DUTY_SCALE;
  assign thr_tl  = 32'(D_TURN_L * DUTY_SCALE);
  assign thr_tr  = 32'(D_TURN_R * DUTY_SCALE);

  // Last phase count of each interval; dir codes 01 and 11 both turn right.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    dly_last = PH_W'(DLY_R - 1);
    trn_last = PH_W'(TRN_R - 1);
    case (act)
      2'b10: begin
        dly_last = PH_W'(DLY_L - 1);
        trn_last = PH_W'(TRN_L - 1);
      end
      2'b11: begin
        dly_last = PH_W'(DLY_U - 1);
        trn_last = PH_W'(TRN_U - 1);
      end
      default: ;
    endcase
  end

  always_comb begin
    next_a = COAST;
    next_b = COAST;
    if (stop) begin
      next_a = BRAKE;
      next_b = BRAKE;
    end else if (state == TURN) begin
      if (act == 2'b10) begin
        if (pwm_ext <= thr_tl) begin
          next_a = FWD;
          next_b = REV;
        end
      end else if (pwm_ext <= thr_tr) begin
        next_a = REV;
        next_b = FWD;
      end
    end else begin
      if (pwm_ext <= thr_a) next_a = FWD;
      if (pwm_ext <= thr_b) next_b = FWD;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it is just the highest-priority branch of the clocked block.
    if (!rst_n) begin
      state     <= FOLLOW;
      act       <= 2'b00;
      phase_cnt <= '0;
      last_node <= '0;
      pwm_cnt   <= PWM_W'(1);
      duty_a    <= P_BASE;
      duty_b    <= P_BASE;
      motor_a   <= COAST;
      motor_b   <= COAST;
      turn_busy <= 1'b0;
      turn_done <= 1'b0;
    end else begin
      // NOTE: all state uses non-blocking assignment so every register sees pre-edge values.
      pwm_cnt   <= (pwm_cnt == PWM_W'(PERIOD)) ? PWM_W'(1) : pwm_cnt + PWM_W'(1);
      motor_a   <= next_a;
      motor_b   <= next_b;
      turn_done <= 1'b0;

      if (state == FOLLOW) begin
        case (line_sensor)
          3'b100:          begin duty_a <= P_SOFT;  duty_b <= P_SOFTL; end
          3'b110:          begin duty_a <= P_HARD;  duty_b <= P_BASE;  end
          3'b010, 3'b111:  begin duty_a <= P_BASE;  duty_b <= P_BASE;  end
          3'b011:          begin duty_a <= P_BASE;  duty_b <= P_HARD;  end
          3'b001:          begin duty_a <= P_SOFTL; duty_b <= P_SOFT;  end
          default: ;
        endcase
      end

      // A brake request freezes the sequencer so it resumes exactly where it stopped.
      if (!stop) begin
        case (state)
          FOLLOW: begin
            if (dir != 2'b00 && node_id != last_node) begin
              state     <= DELAY;
              act       <= dir;
              phase_cnt <= '0;
              turn_busy <= 1'b1;
            end
          end
          DELAY: begin
            if (phase_cnt == dly_last) begin
              state     <= TURN;
              phase_cnt <= '0;
            end else begin
              phase_cnt <= phase_cnt + PH_W'(1);
            end
          end
          TURN: begin
            if (phase_cnt == trn_last) begin
              state     <= FOLLOW;
              phase_cnt <= '0;
              last_node <= node_id;
              turn_busy <= 1'b0;
              turn_done <= 1'b1;
            end else begin
              phase_cnt <= phase_cnt + PH_W'(1);
            end
          end
          default: state <= FOLLOW;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_motor_drive_seq.sv
// Directed bench for motor_drive_seq with a short PWM period and short turn timings.
// Expected pin values come from hand timelines plus a free-running PWM count model.
module tb_motor_drive_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] line_sensor;
  logic       stop;
  logic [7:0] node_id;
  logic [1:0] dir;
  logic [1:0] motor_a;
  logic [1:0] motor_b;
  logic       turn_busy;
  logic       turn_done;

  int n_checks = 0;
  int n_errors = 0;

  motor_drive_seq #(
    .PERIOD(100), .DUTY_SCALE(1),
    .DLY_L(10), .DLY_R(10), .DLY_U(10),
    .TRN_L(20), .TRN_R(20), .TRN_U(40)
  ) dut (
    .clk(clk), .rst_n(rst_n), .line_sensor(line_sensor), .stop(stop),
    .node_id(node_id), .dir(dir), .motor_a(motor_a), .motor_b(motor_b),
    .turn_busy(turn_busy), .turn_done(turn_done)
  );

  always #5 clk = ~clk;

  // PWM count model: m_prev is the count the outputs sampled at the latest edge were built from.
  int m_cnt  = 1;
  int m_prev = 1;
  always @(posedge clk) begin
    m_prev <= m_cnt;
    m_cnt  <= !rst_n ? 1 : ((m_cnt == 100) ? 1 : m_cnt + 1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // {motor_a, motor_b}: mode 0 straight follow at 73%, 1 left turn at 87%, 2 right turn at 85%.
  function automatic logic [3:0] exp_mot(input int mode, input int p);
    case (mode)
      1:       return (p <= 87) ? 4'b1001 : 4'b0000;
      2:       return (p <= 85) ? 4'b0110 : 4'b0000;
      default: return (p <= 73) ? 4'b1010 : 4'b0000;
    endcase
  endfunction

  task automatic measure(input int n, output int a_on, output int a_off, output int b_on);
    a_on = 0; a_off = 0; b_on = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (motor_a == 2'b10) a_on++;
      if (motor_a == 2'b00) a_off++;
      if (motor_b == 2'b10) b_on++;
    end
  endtask

  // Walks a whole turn sample by sample; eff counts edges on which the sequencer was not braked.
  task automatic run_turn(input string tag, input logic [1:0] d, input logic [7:0] n,
                          input logic [1:0] d_mid, input int trn, input int mode,
                          input int stop_at, input int stop_len);
    int eff = 0, eff_prev, bad_m = 0, bad_b = 0, bad_d = 0, n_done = 0;
    logic stp;
    logic [3:0] em;
    dir = d;
    node_id = n;
    for (int s = 1; s <= 13 + trn + stop_len; s++) begin
      stp  = (stop_len > 0) && (s >= stop_at) && (s < stop_at + stop_len);
      stop = stp;
      if (s == 5) dir = d_mid;
      @(negedge clk);
      eff_prev = eff;
      if (!stp) eff++;
      if (stp) em = 4'b1111;
      else if (eff_prev >= 11 && eff_prev <= 10 + trn) em = exp_mot(mode, m_prev);
      else em = exp_mot(0, m_prev);
      if ({motor_a, motor_b} !== em) bad_m++;
      if (turn_busy !== (eff >= 1 && eff <= 10 + trn)) bad_b++;
      if (turn_done !== (!stp && eff == 11 + trn)) bad_d++;
      if (turn_done === 1'b1) n_done++;
    end
    stop = 1'b0;
    check({tag, "_motor_bad_samples"}, bad_m, 0);
    check({tag, "_busy_bad_samples"}, bad_b, 0);
    check({tag, "_done_bad_samples"}, bad_d, 0);
    check({tag, "_done_pulses"}, n_done, 1);
  endtask

  initial begin
    int a_on, a_off, b_on, busy_cnt;
    rst_n = 1'b0; line_sensor = 3'b010; stop = 1'b0; dir = 2'b00; node_id = 8'd0;
    repeat (2) @(negedge clk);
    check("reset_motor", {motor_a, motor_b}, 4'b0000);
    check("reset_busy", turn_busy, 1'b0);
    check("reset_done", turn_done, 1'b0);

    rst_n = 1'b1;
    @(negedge clk);
    measure(100, a_on, a_off, b_on);
    check("follow_a_on", a_on, 73);
    check("follow_a_off", a_off, 27);
    check("follow_b_on", b_on, 73);

    line_sensor = 3'b100;
    repeat (3) @(negedge clk);
    measure(100, a_on, a_off, b_on);
    check("soft_a_on", a_on, 83);
    check("soft_b_on", b_on, 68);
    line_sensor = 3'b000;
    repeat (3) @(negedge clk);
    measure(100, a_on, a_off, b_on);
    check("hold_a_on", a_on, 83);
    check("hold_b_on", b_on, 68);
    line_sensor = 3'b010;
    repeat (3) @(negedge clk);

    run_turn("left", 2'b10, 8'd5, 2'b10, 20, 1, 0, 0);
    busy_cnt = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (turn_busy !== 1'b0) busy_cnt++;
    end
    check("left_no_retrigger", busy_cnt, 0);

    dir = 2'b00; node_id = 8'd20;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (turn_busy !== 1'b0) busy_cnt++;
    end
    check("straight_no_turn", busy_cnt, 0);

    // Right turn with dir flipped to left during DELAY and a 30-cycle brake mid-TURN.
    run_turn("right_stop", 2'b01, 8'd7, 2'b10, 20, 2, 20, 30);

    dir = 2'b11; node_id = 8'd9;
    repeat (5) @(negedge clk);
    check("uturn_delay_busy", turn_busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_motor", {motor_a, motor_b}, 4'b0000);
    check("abort_busy", turn_busy, 1'b0);
    check("abort_done", turn_done, 1'b0);
    rst_n = 1'b1;
    run_turn("uturn_after_reset", 2'b11, 8'd9, 2'b11, 40, 2, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
